axi4_lite_reg_slave: RTL

AXI4-Lite slave endpoint that terminates an axi4_lite_if master and exposes a bank of NUM_REGS software-writable/readable registers to downstream logic. It sits directly downstream of the AXI4-Lite interface and consumes the master's AW/W/B/AR/R traffic. Fabric logic reads the current register contents and per-register write-strobe pulses. Read and write channels run as independent state machines.

---
 rtl/axi4_lite_pkg.sv | 10 +
 rtl/axi4_lite_if.sv | 40 ++++
 rtl/axi4_lite_reg_slave.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and channel FSM state types.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite bus bundle (AW/W/B/AR/R) with master and slave views.
// Handshake rule on every channel: a beat transfers on a rising clock edge
// where valid and ready are both high; once valid is raised its payload
// stays stable until that edge; ready may depend on state, never on valid.
interface axi4_lite_if #(
  parameter int ADDR_BYTES = 4,
  parameter int DATA_BYTES = 4
);
  logic                    awvalid;
  logic                    awready;
  logic [ADDR_BYTES*8-1:0] awaddr;
  logic [2:0]              awprot;
  logic                    wvalid;
  logic                    wready;
  logic [DATA_BYTES*8-1:0] wdata;
  logic [DATA_BYTES-1:0]   wstrb;
  logic                    bvalid;
  logic                    bready;
  logic [1:0]              bresp;
  logic                    arvalid;
  logic                    arready;
  logic [ADDR_BYTES*8-1:0] araddr;
  logic [2:0]              arprot;
  logic                    rvalid;
  logic                    rready;
  logic [DATA_BYTES*8-1:0] rdata;
  logic [1:0]              rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi4_lite_reg_slave.sv
// AXI4-Lite register bank: NUM_REGS byte-strobed registers behind
// independent write (AW+W -> B) and read (AR -> R) state machines.
module axi4_lite_reg_slave
  import axi4_lite_pkg::*;
#(
  parameter int DATA_BYTES = 4,
  parameter int ADDR_BYTES = 4,
  parameter int NUM_REGS   = 16
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  axi4_lite_if.slave                       s_axi,
  output logic [NUM_REGS*DATA_BYTES*8-1:0] reg_q,
  output logic [NUM_REGS-1:0]              reg_wr,
  output wr_state_t                        wr_state_dbg,
  output rd_state_t                        rd_state_dbg
);
  localparam int DW    = DATA_BYTES * 8;
  localparam int AW    = ADDR_BYTES * 8;
  localparam int OFF_W = $clog2(DATA_BYTES);
  localparam int IDX_W = $clog2(NUM_REGS);
  localparam logic [AW-1:0] ADDR_LIMIT = AW'(NUM_REGS * DATA_BYTES);

  wr_state_t               wr_state_q, wr_state_d;
  logic                    aw_held_q, aw_held_d;
  logic                    w_held_q, w_held_d;
  logic [AW-1:0]           awaddr_q, awaddr_d;
  logic [DW-1:0]           wdata_q, wdata_d;
  logic [DATA_BYTES-1:0]   wstrb_q, wstrb_d;
  logic                    bvalid_q, bvalid_d;
  logic [1:0]              bresp_q, bresp_d;
  logic [NUM_REGS-1:0]     reg_wr_q, reg_wr_d;
  logic [DW-1:0]           regs_q [NUM_REGS];
  logic [DW-1:0]           regs_d [NUM_REGS];

  rd_state_t               rd_state_q, rd_state_d;
  logic                    rvalid_q, rvalid_d;
  logic [DW-1:0]           rdata_q, rdata_d;
  logic [1:0]              rresp_q, rresp_d;

  logic                    awready_c, wready_c, arready_c;
  logic                    aw_hs, w_hs;
  logic [AW-1:0]           wr_addr;
  logic [DW-1:0]           wr_data;
  logic [DATA_BYTES-1:0]   wr_strb;
  logic [IDX_W-1:0]        wr_idx, rd_idx;
  logic [5:0]              prot_unused;

  assign prot_unused = {s_axi.awprot, s_axi.arprot};

  // Write channel: capture AW and W independently, commit once both are present.
  always_comb begin
    wr_state_d = wr_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    reg_wr_d   = '0;
    regs_d     = regs_q;
    awready_c  = 1'b0;
    wready_c   = 1'b0;
    aw_hs      = 1'b0;
    w_hs       = 1'b0;
    // A beat arriving this cycle is used directly; a held one comes from its flop.
    wr_addr    = aw_held_q ? awaddr_q : s_axi.awaddr;
    wr_data    = w_held_q ? wdata_q : s_axi.wdata;
    wr_strb    = w_held_q ? wstrb_q : s_axi.wstrb;
    wr_idx     = wr_addr[OFF_W +: IDX_W];
    case (wr_state_q)
      WR_IDLE: begin
        awready_c = aresetn && !aw_held_q;
        wready_c  = aresetn && !w_held_q;
        aw_hs     = s_axi.awvalid && awready_c;
        w_hs      = s_axi.wvalid && wready_c;
        if (aw_hs) begin
          aw_held_d = 1'b1;
          awaddr_d  = s_axi.awaddr;
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          wdata_d  = s_axi.wdata;
          wstrb_d  = s_axi.wstrb;
        end
        if ((aw_held_q || aw_hs) && (w_held_q || w_hs)) begin
          wr_state_d = WR_RESP;
          bvalid_d   = 1'b1;
          if (wr_addr < ADDR_LIMIT) begin
            for (int b = 0; b < DATA_BYTES; b++) begin
              if (wr_strb[b]) regs_d[wr_idx][b*8 +: 8] = wr_data[b*8 +: 8];
            end
            reg_wr_d[wr_idx] = 1'b1;
            bresp_d          = RESP_OKAY;
          end else begin
            bresp_d = RESP_SLVERR;
          end
        end
      end
      WR_RESP: begin
        if (bvalid_q && s_axi.bready) begin
          wr_state_d = WR_IDLE;
          bvalid_d   = 1'b0;
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  // Write channel and register bank state.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_state_q <= WR_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      reg_wr_q   <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      reg_wr_q   <= reg_wr_d;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  // Read channel: sample the pre-write register value on AR, hold R until taken.
  always_comb begin
    rd_state_d = rd_state_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    arready_c  = 1'b0;
    rd_idx     = s_axi.araddr[OFF_W +: IDX_W];
    case (rd_state_q)
      RD_IDLE: begin
        arready_c = aresetn;
        if (s_axi.arvalid && arready_c) begin
          rd_state_d = RD_DATA;
          rvalid_d   = 1'b1;
          if (s_axi.araddr < ADDR_LIMIT) begin
            rdata_d = regs_q[rd_idx];
            rresp_d = RESP_OKAY;
          end else begin
            rdata_d = '0;
            rresp_d = RESP_SLVERR;
          end
        end
      end
      RD_DATA: begin
        if (rvalid_q && s_axi.rready) begin
          rd_state_d = RD_IDLE;
          rvalid_d   = 1'b0;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  // Read channel state.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rd_state_q <= RD_IDLE;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      rd_state_q <= rd_state_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  // Flatten the register array onto the fabric-facing bus.
  always_comb begin
    reg_q = '0;
    for (int i = 0; i < NUM_REGS; i++) reg_q[i*DW +: DW] = regs_q[i];
  end

  assign s_axi.awready = awready_c;
  assign s_axi.wready  = wready_c;
  assign s_axi.arready = arready_c;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;
  assign reg_wr        = reg_wr_q;
  assign wr_state_dbg  = wr_state_q;
  assign rd_state_dbg  = rd_state_q;

endmodule
